// File: rtl/img_pos_ctrl.sv
// Bouncing-image origin controller: once per frame, at the end-of-frame pixel,
// steps the displayed image origin and reflects it off the active-area edges.
module img_pos_ctrl #(
  parameter int H_ACT  = 640,
  parameter int V_ACT  = 480,
  parameter int IMG_W  = 360,
  parameter int IMG_H  = 200,
  parameter int INIT_X = 50,
  parameter int INIT_Y = 50,
  parameter int EOF_X  = 630,
  parameter int EOF_Y  = 470
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic [9:0] X,
  input  logic [9:0] Y,
  input  logic       en,
  input  logic [2:0] speed,
  output logic [9:0] org_x,
  output logic [9:0] org_y,
  output logic       frame_tick,
  output logic       bounce_x,
  output logic       bounce_y,
  output logic       busy
);

  // state    | meaning
  // IDLE     | motion disabled, origin and directions held
  // WAIT_EOF | waiting for the end-of-frame pixel
  // UPD_X    | compute shadow X, speed already latched
  // UPD_Y    | compute shadow Y
  // COMMIT   | shadows loaded into the origin on exit, pulses driven
  typedef enum logic [2:0] {IDLE, WAIT_EOF, UPD_X, UPD_Y, COMMIT} state_t;

  localparam logic [10:0] X_MAX = 11'(H_ACT - IMG_W);
  localparam logic [10:0] Y_MAX = 11'(V_ACT - IMG_H);

  state_t     state_q, state_d;
  logic [9:0] org_x_q, org_x_d, org_y_q, org_y_d;
  logic [9:0] shd_x_q, shd_x_d, shd_y_q, shd_y_d;
  logic       dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic [2:0] spd_q, spd_d;
  logic       bnc_x_q, bnc_x_d, bnc_y_q, bnc_y_d;
  logic       tick_q, tick_d, bx_q, bx_d, by_q, by_d, busy_q, busy_d;
  logic       eof_hit;
  logic [10:0] step_x, step_y;

  // Returns {bounce, new_pos}; fwd=1 means increasing coordinate.
  function automatic logic [10:0] step_pos(input logic [9:0] pos, input logic [2:0] s,
                                           input logic fwd, input logic [10:0] lim);
    logic [10:0] p11, s11, sum;
    logic [9:0]  res;
    logic        bnc;
    p11 = {1'b0, pos};
    s11 = {8'd0, s};
    sum = p11 + s11;
    if (fwd) begin
      if (sum > lim) begin res = 10'(lim); bnc = 1'b1; end
      else           begin res = 10'(sum); bnc = 1'b0; end
    end else begin
      if (p11 < s11) begin res = '0;              bnc = 1'b1; end
      else           begin res = 10'(p11 - s11);  bnc = 1'b0; end
    end
    return {bnc, res};
  endfunction

  assign eof_hit = (X == 10'(EOF_X)) && (Y == 10'(EOF_Y));
  assign step_x  = step_pos(org_x_q, spd_q, dir_x_q, X_MAX);
  assign step_y  = step_pos(org_y_q, spd_q, dir_y_q, Y_MAX);

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q <= IDLE;
      org_x_q <= 10'(INIT_X);
      org_y_q <= 10'(INIT_Y);
      dir_x_q <= 1'b1;
      dir_y_q <= 1'b1;
      shd_x_q <= '0;
      shd_y_q <= '0;
      spd_q   <= '0;
      bnc_x_q <= 1'b0;
      bnc_y_q <= 1'b0;
      tick_q  <= 1'b0;
      bx_q    <= 1'b0;
      by_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      org_x_q <= org_x_d;
      org_y_q <= org_y_d;
      dir_x_q <= dir_x_d;
      dir_y_q <= dir_y_d;
      shd_x_q <= shd_x_d;
      shd_y_q <= shd_y_d;
      spd_q   <= spd_d;
      bnc_x_q <= bnc_x_d;
      bnc_y_q <= bnc_y_d;
      tick_q  <= tick_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (en) state_d = WAIT_EOF;
      WAIT_EOF: if (!en) state_d = IDLE;
                else if (eof_hit) state_d = UPD_X;
      UPD_X:    state_d = UPD_Y;
      UPD_Y:    state_d = COMMIT;
      COMMIT:   state_d = en ? WAIT_EOF : IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    org_x_d = org_x_q;
    org_y_d = org_y_q;
    dir_x_d = dir_x_q;
    dir_y_d = dir_y_q;
    shd_x_d = shd_x_q;
    shd_y_d = shd_y_q;
    spd_d   = spd_q;
    bnc_x_d = bnc_x_q;
    bnc_y_d = bnc_y_q;
    tick_d  = 1'b0;
    bx_d    = 1'b0;
    by_d    = 1'b0;
    busy_d  = (state_d == UPD_X) || (state_d == UPD_Y) || (state_d == COMMIT);
    case (state_q)
      WAIT_EOF: if (state_d == UPD_X) spd_d = speed;
      UPD_X: begin
        shd_x_d = step_x[9:0];
        bnc_x_d = step_x[10];
        dir_x_d = dir_x_q ^ step_x[10];
      end
      UPD_Y: begin
        shd_y_d = step_y[9:0];
        bnc_y_d = step_y[10];
        dir_y_d = dir_y_q ^ step_y[10];
      end
      COMMIT: begin
        org_x_d = shd_x_q;
        org_y_d = shd_y_q;
        tick_d  = 1'b1;
        bx_d    = bnc_x_q;
        by_d    = bnc_y_q;
      end
      default: ;
    endcase
  end

  assign org_x      = org_x_q;
  assign org_y      = org_y_q;
  assign frame_tick = tick_q;
  assign bounce_x   = bx_q;
  assign bounce_y   = by_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_img_pos_ctrl.sv
// Scoreboard bench for img_pos_ctrl: each end-of-frame stimulus pushes the
// model's expected origin/bounces, checked when frame_tick appears.
module tb_img_pos_ctrl;

  logic       pclk = 1'b0;
  logic       rst;
  logic [9:0] X, Y;
  logic       en;
  logic [2:0] speed;
  logic [9:0] org_x, org_y;
  logic       frame_tick, bounce_x, bounce_y, busy;

  img_pos_ctrl dut (
    .pclk(pclk), .rst(rst), .X(X), .Y(Y), .en(en), .speed(speed),
    .org_x(org_x), .org_y(org_y), .frame_tick(frame_tick),
    .bounce_x(bounce_x), .bounce_y(bounce_y), .busy(busy)
  );

  always #5 pclk = ~pclk;

  typedef struct {int ox; int oy; int bx; int by; int k;} exp_t;
  exp_t sb_q[$];

  int n_chk = 0, n_err = 0;
  int cyc = 0;
  int tick_cnt = 0;
  logic rst_s = 1'b1;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(posedge pclk) begin
    cyc   <= cyc + 1;
    rst_s <= rst;
  end

  // Monitor: compares every tick against the scoreboard and checks that the
  // origin holds still between ticks.
  int cur_ox = 50, cur_oy = 50;
  always @(negedge pclk) begin
    if (rst_s) begin
      cur_ox = 50;
      cur_oy = 50;
      chk("rst_tick", frame_tick, 0);
    end else if (frame_tick) begin
      tick_cnt++;
      if (sb_q.size() == 0) begin
        chk("tick_unexpected", frame_tick, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("latency", cyc, e.k + 3);
        chk("org_x", org_x, e.ox);
        chk("org_y", org_y, e.oy);
        chk("bounce_x", bounce_x, e.bx);
        chk("bounce_y", bounce_y, e.by);
        cur_ox = e.ox;
        cur_oy = e.oy;
      end
    end else begin
      chk("org_x_hold", org_x, cur_ox);
      chk("org_y_hold", org_y, cur_oy);
      chk("bounce_idle", {31'd0, bounce_x | bounce_y}, 0);
    end
  end

  int  m_ox, m_oy;
  bit  m_dx, m_dy;

  task automatic mstep(inout int p, inout bit d, input int s, input int lim, output int b);
    b = 0;
    if (d) begin
      if (p + s > lim) begin p = lim; d = 1'b0; b = 1; end
      else p = p + s;
    end else begin
      if (p < s) begin p = 0; d = 1'b1; b = 1; end
      else p = p - s;
    end
  endtask

  task automatic model_reset();
    m_ox = 50; m_oy = 50; m_dx = 1'b1; m_dy = 1'b1;
  endtask

  // Called just after a negedge; drives one EOF match cycle.
  task automatic apply_eof(input int spd, input bit push);
    exp_t e;
    X = 10'd630; Y = 10'd470; speed = 3'(spd);
    if (push) begin
      mstep(m_ox, m_dx, spd, 280, e.bx);
      mstep(m_oy, m_dy, spd, 280, e.by);
      e.ox = m_ox; e.oy = m_oy; e.k = cyc + 1;
      sb_q.push_back(e);
    end
    @(negedge pclk);
    X = 10'd0; Y = 10'd0;
  endtask

  task automatic frame(input int spd, input bit push);
    apply_eof(spd, push);
    repeat (4) @(negedge pclk);
  endtask

  int t0;

  initial begin
    rst = 1'b1; en = 1'b0; X = '0; Y = '0; speed = '0;
    model_reset();
    repeat (2) @(negedge pclk);
    chk("rst_org_x", org_x, 50);
    chk("rst_org_y", org_y, 50);
    chk("rst_busy", busy, 0);
    chk("rst_bnc", {30'd0, bounce_x, bounce_y}, 0);
    rst = 1'b0;
    // EOF while idle is ignored
    apply_eof(3, 1'b0);
    repeat (4) @(negedge pclk);
    en = 1'b1;
    @(negedge pclk);

    // Basic step with busy window; speed changes after latch must not matter
    apply_eof(3, 1'b1);
    speed = 3'd7;
    chk("busy_k0", busy, 1);
    @(negedge pclk); chk("busy_k1", busy, 1);
    @(negedge pclk); chk("busy_k2", busy, 1);
    @(negedge pclk); chk("busy_k3", busy, 0);
    chk("org_x_53", org_x, 53);
    chk("org_y_53", org_y, 53);
    @(negedge pclk); chk("tick_one_cycle", frame_tick, 0);

    // Reset asserted while in UPD_Y abandons the frame
    apply_eof(3, 1'b0);
    @(negedge pclk);
    rst = 1'b1;
    @(negedge pclk);
    chk("rst_mid_org_x", org_x, 50);
    chk("rst_mid_org_y", org_y, 50);
    chk("rst_mid_busy", busy, 0);
    model_reset();
    // EOF coincident with reset is not committed
    apply_eof(3, 1'b0);
    rst = 1'b0;
    repeat (5) @(negedge pclk);
    chk("rst_no_busy", busy, 0);

    // speed 0: ticks but no movement
    t0 = tick_cnt;
    for (int i = 0; i < 3; i++) frame(0, 1'b1);
    chk("spd0_ticks", tick_cnt - t0, 3);
    chk("spd0_org_x", org_x, 50);

    // Walk right to 278, then bounce on the right edge
    for (int i = 0; i < 100 && m_ox != 278; i++) frame(4, 1'b1);
    chk("pre_278", org_x, 278);
    frame(4, 1'b1);
    chk("edge_280", org_x, 280);
    frame(4, 1'b1);
    chk("back_276", org_x, 276);

    // Walk left to 2, then bounce on the left edge
    for (int i = 0; i < 200 && m_ox != 2; i++) frame(2, 1'b1);
    chk("pre_2", org_x, 2);
    frame(5, 1'b1);
    chk("edge_0", org_x, 0);
    frame(5, 1'b1);
    chk("fwd_5", org_x, 5);

    // Drop en during the update: commit still happens, then idle
    t0 = tick_cnt;
    apply_eof(1, 1'b1);
    en = 1'b0;
    repeat (4) @(negedge pclk);
    chk("en_drop_tick", tick_cnt - t0, 1);
    chk("en_drop_busy", busy, 0);
    frame(3, 1'b0);
    frame(3, 1'b0);
    chk("en_off_no_tick", tick_cnt - t0, 1);
    en = 1'b1;
    @(negedge pclk);
    frame(3, 1'b1);
    chk("en_back_tick", tick_cnt - t0, 2);

    repeat (3) @(negedge pclk);
    chk("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/img_pos_ctrl.md
IMG_POS_CTRL -- requirements
Module: img_pos_ctrl

Interface
REQ-001 Parameters SHALL be:
- H_ACT, 640, active width in pixels
- V_ACT, 480, active height in lines
- IMG_W, 360, displayed image width
- IMG_H, 200, displayed image height
- INIT_X, 50, reset origin X
- INIT_Y, 50, reset origin Y
- EOF_X, 630, end-of-frame trigger column
- EOF_Y, 470, end-of-frame trigger line
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 Ports SHALL be:
- pclk  in  1  pixel clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- X  in  10  current pixel column from timing generator
- Y  in  10  current pixel line from timing generator
- en  in  1  motion enable
- speed  in  3  step size in pixels per frame, 0..7
- org_x  out  10  image origin column for the image-display block
- org_y  out  10  image origin line for the image-display block
- frame_tick  out  1  one-cycle pulse when a new origin is committed
- bounce_x  out  1  one-cycle pulse, X direction flipped this commit
- bounce_y  out  1  one-cycle pulse, Y direction flipped this commit
- busy  out  1  high while in UPD_X, UPD_Y or COMMIT

Function
REQ-004 The FSM SHALL have states IDLE, WAIT_EOF, UPD_X, UPD_Y and COMMIT.
REQ-005 Transitions SHALL be:
- IDLE->WAIT_EOF when en=1.
- WAIT_EOF->UPD_X when X==EOF_X and Y==EOF_Y.
- WAIT_EOF->IDLE when en=0.
- UPD_X->UPD_Y->COMMIT unconditionally.
- COMMIT->WAIT_EOF if en=1, else IDLE.
REQ-006 The EOF match SHALL be evaluated only in WAIT_EOF; a match in any other state SHALL be ignored.
REQ-007 speed SHALL be latched on the same edge that enters UPD_X; speed changes after that edge SHALL NOT affect the update in progress.
REQ-008 UPD_X SHALL compute shadow X from org_x, dir_x and the latched step s; org_x SHALL NOT change in this state.
- dir_x=right and org_x+s > H_ACT-IMG_W: shadow = H_ACT-IMG_W, dir_x flips, X-bounce flag set.
- dir_x=left and org_x < s: shadow = 0, dir_x flips, X-bounce flag set.
- Otherwise: shadow = org_x ± s.
REQ-009 UPD_Y SHALL apply the same rule to org_y, dir_y and V_ACT-IMG_H, producing shadow Y and a Y-bounce flag.
REQ-010 All position arithmetic SHALL be done at 11-bit width so that no intermediate value wraps.
REQ-011 org_x and org_y SHALL NOT exceed H_ACT-IMG_W (280) and V_ACT-IMG_H (280) respectively.
REQ-012 On the edge leaving COMMIT, the block SHALL load org_x and org_y from the shadows and drive frame_tick=1, with bounce_x and bounce_y equal to their flags, for exactly one cycle.
REQ-013 Latency: with the EOF match sampled at edge k, org_x, org_y and the pulses SHALL update at edge k+3.
REQ-014 org_x and org_y SHALL change at no other time, so the origin is stable for the whole active frame.
REQ-015 speed=0: the block SHALL still traverse the FSM and pulse frame_tick, origins SHALL remain unchanged and no bounce SHALL occur.
REQ-016 en deasserted during UPD_X, UPD_Y or COMMIT: the update SHALL complete and commit, then the FSM SHALL go to IDLE.
REQ-017 In IDLE, org_x, org_y, dir_x and dir_y SHALL hold their values.
REQ-018 busy SHALL be a registered decode of the state.

Reset
REQ-019 rst=1 at any edge, including mid-update, SHALL force the following:
- state=IDLE
- org_x=INIT_X, org_y=INIT_Y
- dir_x=right, dir_y=down
- shadows and latched speed = 0
- frame_tick=0, bounce_x=0, bounce_y=0, busy=0
REQ-020 No update SHALL be committed for a frame whose EOF match coincided with rst=1.

Verification
REQ-021 Reset, en=1, speed=3, drive one EOF match (X=630, Y=470) -> org_x=53, org_y=53, frame_tick high one cycle exactly 3 edges after the match, busy high for 3 cycles.
REQ-022 Preload org_x=278 (dir right), speed=4, EOF -> org_x=280, bounce_x=1 with frame_tick; next EOF -> org_x=276, bounce_x=0.
REQ-023 org_x=2 (dir left), speed=5, EOF -> org_x=0, dir_x=right, bounce_x=1; next EOF -> org_x=5.
REQ-024 speed=0, three EOF matches -> three frame_tick pulses, org_x=50 and org_y=50 unchanged, no bounce pulses.
REQ-025 Assert rst on the cycle the FSM is in UPD_Y -> next cycle org_x=50, org_y=50, state IDLE, frame_tick never pulses for that frame.
REQ-026 Drop en one cycle after the EOF match -> commit still occurs at k+3, then the FSM goes to IDLE; further EOF matches -> no frame_tick until en=1.
